// File: rtl/display_scanner_pkg.sv
// Shared types and defaults for the 7-segment scan block.
// No logic: enum, default timing constants and a sizing helper.
// No handshake of its own; consumed by display_scanner and its testbench.
package display_scanner_pkg;

    typedef enum logic {BLANK, SHOW} scan_state_t;

    localparam int DEF_NDIGITS      = 8;
    localparam int DEF_DIGIT_CYCLES = 100000;
    localparam int DEF_BLANK_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// Bundles the display value/control inputs and the scan outputs.
// Pure wiring, zero latency.
// No backpressure: load is a strobe; outputs are free-running.
interface display_scanner_if #(
    parameter int NDIGITS = 8
);
    logic [4*NDIGITS-1:0] value_in;
    logic                 load;
    logic [NDIGITS-1:0]   enable_mask;
    logic                 lz_blank;
    logic [3:0]           hexdigit;
    logic [NDIGITS-1:0]   digitselect;
    logic                 frame_done;
    logic                 update_pending;

    modport master (
        output value_in, load, enable_mask, lz_blank,
        input  hexdigit, digitselect, frame_done, update_pending
    );

    modport slave (
        input  value_in, load, enable_mask, lz_blank,
        output hexdigit, digitselect, frame_done, update_pending
    );
endinterface

// File: rtl/lz_detect.sv
// Leading-zero blanking: digit i stays lit unless it and every digit above it are zero.
// Combinational, zero latency. Digit 0 is always reported lit.
// No backpressure.
module lz_detect #(
    parameter int NDIGITS = 8
) (
    input  logic [4*NDIGITS-1:0] value_i,
    input  logic                 lz_blank_i,
    output logic [NDIGITS-1:0]   lit_mask_o
);

    logic zero_above;

    always_comb begin
        lit_mask_o = '1;
        zero_above = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (value_i[4*i +: 4] == 4'h0);
            if (lz_blank_i && zero_above) begin
                lit_mask_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexes a double-buffered hex value across NDIGITS common-segment digits.
// Outputs registered: they reflect the state entered on each edge; commits land at frame wrap.
// No backpressure: load is accepted every cycle, last load in a frame wins.
module display_scanner
    import display_scanner_pkg::*;
#(
    parameter int NDIGITS      = DEF_NDIGITS,
    parameter int DIGIT_CYCLES = DEF_DIGIT_CYCLES,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(max_int(DIGIT_CYCLES, BLANK_CYCLES) + 1);
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIGITS - 1);
    // With no guard gap the scan never visits BLANK, so SHOW is both entry and loop state.
    localparam scan_state_t      GAP_STATE  = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    scan_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*NDIGITS-1:0] active_q, active_d;
    logic [4*NDIGITS-1:0] shadow_q, shadow_d;
    logic                 pending_q, pending_d;
    logic [3:0]           hexdigit_q, hexdigit_d;
    logic [NDIGITS-1:0]   digitselect_q, digitselect_d;
    logic                 frame_done_q, frame_done_d;
    logic                 commit;
    logic                 lit_now;
    logic [NDIGITS-1:0]   lit_mask;

    // Blanking looks at the value about to be displayed so a fresh commit is judged correctly.
    lz_detect #(
        .NDIGITS (NDIGITS)
    ) u_lz_detect (
        .value_i    (active_d),
        .lz_blank_i (bus.lz_blank),
        .lit_mask_o (lit_mask)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= GAP_STATE;
            idx_q         <= '0;
            cnt_q         <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            hexdigit_q    <= 4'h0;
            digitselect_q <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            hexdigit_q    <= hexdigit_d;
            digitselect_q <= digitselect_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + CNT_W'(1);
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        commit       = 1'b0;

        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = GAP_STATE;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        commit = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = GAP_STATE;
                cnt_d   = '0;
            end
        endcase

        // Commit takes the old shadow; a coinciding load refills the shadow and keeps pending set.
        if (commit && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (bus.load) begin
            shadow_d  = bus.value_in;
            pending_d = 1'b1;
        end
        frame_done_d = commit;
    end

    always_comb begin
        hexdigit_d    = active_d[4*idx_d +: 4];
        lit_now       = (state_d == SHOW) && bus.enable_mask[idx_d] && lit_mask[idx_d];
        digitselect_d = lit_now ? ~(NDIGITS'(1) << idx_d) : '1;
    end

    assign bus.hexdigit       = hexdigit_q;
    assign bus.digitselect    = digitselect_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.update_pending = pending_q;

endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench for display_scanner (8 digits, 4 lit + 1 guard clock per slot).
// The reference tracks absolute scan position since reset and derives slot/phase arithmetically.
module tb_display_scanner;

    localparam int ND    = 8;
    localparam int DC    = 4;
    localparam int BC    = 1;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = ND * SLOT;

    typedef struct {
        logic [3:0] hex;
        logic       chk_hex;
        logic [7:0] ds;
        logic       fd;
        logic       up;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    display_scanner_if #(.NDIGITS(ND)) bus();

    display_scanner #(
        .NDIGITS      (ND),
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          pos   = 0;
    logic [31:0] m_active = '0;
    logic [31:0] m_shadow = '0;
    logic        m_pend   = 1'b0;
    logic [7:0]  cur_mask = 8'hFF;
    logic        cur_lz   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (pos %0d, t=%0t)", name, act, exp, pos, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, advance the model over the coming rising edge,
    // queue the expected outputs, then wait for the next falling edge.
    task automatic step(input logic [31:0] v, input logic ld);
        exp_t e;
        int   slot;
        bit   commit;
        bit   dark;
        bus.value_in    = v;
        bus.load        = ld;
        bus.enable_mask = cur_mask;
        bus.lz_blank    = cur_lz;
        pos++;
        commit = (pos % FRAME == 0);
        if (commit && m_pend) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
        end
        if (ld) begin
            m_shadow = v;
            m_pend   = 1'b1;
        end
        slot      = (pos % FRAME) / SLOT;
        e.fd      = commit;
        e.up      = m_pend;
        e.chk_hex = (pos % SLOT) != 0;
        e.hex     = m_active[4*slot +: 4];
        dark      = !cur_mask[slot] || (cur_lz && slot > 0 && (m_active >> (4*slot)) == 32'h0);
        e.ds      = (!e.chk_hex || dark) ? 8'hFF : ~(8'h01 << slot);
        q.push_back(e);
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic run_to(input int p);
        while (pos < p) step($urandom, 1'b0);
    endtask

    function automatic int next_commit();
        return (pos / FRAME + 1) * FRAME;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ds"},  32'(bus.digitselect), 32'hFF);
        check({tag, "_hex"}, 32'(bus.hexdigit), 32'h0);
        check({tag, "_up"},  32'(bus.update_pending), 32'h0);
        check({tag, "_fd"},  32'(bus.frame_done), 32'h0);
    endtask

    // Entered at a falling edge; asserts reset mid-cycle and releases it at a later falling edge.
    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, "_async"});
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        pos      = 0;
        m_active = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        check_reset_outputs({tag, "_release"});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("sb_digitselect", 32'(bus.digitselect), 32'(e.ds));
                check("sb_frame_done", 32'(bus.frame_done), 32'(e.fd));
                check("sb_update_pending", 32'(bus.update_pending), 32'(e.up));
                if (e.chk_hex) check("sb_hexdigit", 32'(bus.hexdigit), 32'(e.hex));
            end
        end
    end

    initial begin : driver
        int base;
        bus.value_in    = '0;
        bus.load        = 1'b0;
        bus.enable_mask = 8'hFF;
        bus.lz_blank    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("t1_reset");

        // Scan timing and frame pulse with a zero value.
        step($urandom, 1'b0);
        check("t1_first_slot_ds", 32'(bus.digitselect), 32'hFE);
        run_to(2 * FRAME + 1);

        // Load mid-frame stays hidden until the wrap.
        run_to(2 * FRAME + 3 * SLOT + 2);
        step(32'h1234_5678, 1'b1);
        check("t2_pending_set", 32'(bus.update_pending), 32'h1);
        check("t2_old_value", 32'(bus.hexdigit), 32'h0);
        base = next_commit();
        run_to(base);
        check("t2_frame_done", 32'(bus.frame_done), 32'h1);
        step($urandom, 1'b0);
        check("t2_slot0_hex", 32'(bus.hexdigit), 32'h8);
        check("t2_slot0_ds", 32'(bus.digitselect), 32'hFE);
        run_to(base + 7 * SLOT + 1);
        check("t2_slot7_hex", 32'(bus.hexdigit), 32'h1);
        check("t2_slot7_ds", 32'(bus.digitselect), 32'h7F);
        check("t2_pending_clr", 32'(bus.update_pending), 32'h0);

        // Leading-zero blanking.
        cur_lz = 1'b1;
        step(32'h0000_00A0, 1'b1);
        run_to(next_commit() + FRAME);
        step(32'h0000_0000, 1'b1);
        run_to(next_commit() + FRAME);

        // Per-digit enable.
        cur_lz   = 1'b0;
        cur_mask = 8'h0F;
        step(32'hFFFF_FFFF, 1'b1);
        run_to(next_commit() + FRAME);
        cur_mask = 8'hFF;

        // Load on the commit edge: old shadow commits, new one stays pending.
        run_to(pos + 10);
        step(32'h1111_1111, 1'b1);
        base = next_commit();
        run_to(base - 1);
        step(32'h2222_2222, 1'b1);
        check("t5_pending_kept", 32'(bus.update_pending), 32'h1);
        step($urandom, 1'b0);
        check("t5_first_frame", 32'(bus.hexdigit), 32'h1);
        run_to(base + FRAME + 1);
        check("t5_second_frame", 32'(bus.hexdigit), 32'h2);

        // Asynchronous reset during slot 3 discards a pending update.
        step(32'hDEAD_BEEF, 1'b1);
        run_to(next_commit() + 3 * SLOT + 2);
        reset_pulse("t6");
        step($urandom, 1'b0);
        check("t6_restart_ds", 32'(bus.digitselect), 32'hFE);
        check("t6_restart_hex", 32'(bus.hexdigit), 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 40) == 0) begin
                cur_mask = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
                cur_lz   = 1'($urandom);
            end
            if ($urandom_range(0, 24) == 0)
                step($urandom >> (4 * $urandom_range(0, 7)), 1'b1);
            else
                step($urandom, 1'b0);
        end

        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
